shift_seq: RTL
==============

Name: shift_seq

Overview:
- Multi-cycle shift sequencer for the MIPS datapath. It executes sll/srl/sra by iterating a small fixed-distance shift stage, STEP bits per cycle, instead of using a full barrel shifter.
- Sits beside the ALU in EX.
- Accepts one operation via a valid/ready handshake. Asserts busy so the hazard unit can stall the pipeline, then holds the result until the consumer takes it.

Parameters:
- WIDTH, 32, operand/result width in bits.
- STEP, 2, maximum shift distance applied per cycle (1 <= STEP < WIDTH).
- SW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort; drop any in-flight or held operation.
- in_valid  input  1  operation offered.
- in_ready  output  1  sequencer can accept (state IDLE).
- a  input  WIDTH  operand.
- shamt  input  SW  shift amount.
- op  input  2  00 sll, 01 srl, 11 sra, 10 reserved (executes as sll).
- out_valid  output  1  result held on y.
- out_ready  input  1  consumer takes result.
- y  output  WIDTH  result.
- busy  output  1  state != IDLE; drives the pipeline stall.

Behaviour:
- States: IDLE, SHIFT, DONE. Registers: state, acc[WIDTH], rem[SW], op_q.
- Reset (reset low, asynchronous): state=IDLE, acc=0, rem=0, op_q=sll. Outputs during reset: out_valid=0, y=0, busy=0, in_ready=1.
- in_ready = (state==IDLE) && !flush. Accept = in_valid && in_ready at a rising edge.
- On accept:
  - acc<=a, rem<=shamt, op_q<=op.
  - Next state is DONE if shamt==0, else SHIFT.
- SHIFT, each cycle:
  - k = (rem>=STEP) ? STEP : rem.
  - acc shifted by k: sll fills zeros at the LSBs; srl fills zeros at the MSBs; sra replicates acc[WIDTH-1] (the original sign is preserved throughout).
  - rem<=rem-k.
  - When rem-k==0, next state is DONE.
- DONE:
  - out_valid=1 and y=acc. y is 0 whenever out_valid=0.
  - On out_ready, go to IDLE.
  - y and out_valid stay stable while out_ready is low.
- Latency: if the accept happens in cycle c, out_valid is first high in cycle c+1+ceil(shamt/STEP).
  - shamt=0 gives c+1.
  - shamt=31 with STEP=2 gives c+17.
- Throughput: no accept while busy. A new accept is possible in the cycle after the DONE handshake, so there is no back-to-back overlap.
- flush:
  - Highest priority. At the edge, state<=IDLE; acc and rem are left as-is.
  - While flush is high, no accept occurs even in IDLE, and no result handshake occurs.
  - flush in DONE discards the result.
- Simultaneous out_ready and in_valid in DONE: only the result is consumed. in_ready is 0, so the new operation waits one cycle.
- Asserting reset mid-SHIFT returns to IDLE immediately; after deassertion nothing is pending.
- shamt >= WIDTH cannot be encoded (SW bits). Result for shamt=WIDTH-1 sra = all sign bits.
- in_valid/a/shamt/op are don't-care outside the accept cycle; internal copies are registered.

Decomposition:
- Package shift_pkg holds:
  - typedef enum logic [1:0] shift_op_t {SH_SLL=2'b00, SH_SRL=2'b01, SH_RSV=2'b10, SH_SRA=2'b11}.
  - typedef enum logic [1:0] seq_state_t {S_IDLE, S_SHIFT, S_DONE}.
  - localparam default STEP.
- One sub-module, shift_step: combinational, inputs acc, k (0..STEP) and op; output is acc shifted by k. It generalises the existing fixed 2-bit left shifter to direction/fill selection.
- shift_seq holds the FSM, rem counter and handshake logic.

Test Plan:
- Reset mid-operation: accept a=32'h1, shamt=31, op=sll; pull reset low on the cycle 5 edge -> immediately state IDLE, out_valid=0, y=0, busy=0; after release, no stray out_valid.
- Zero shift: a=32'hDEADBEEF, shamt=0, op=srl, accepted at cycle c -> out_valid in cycle c+1, y=32'hDEADBEEF, busy high exactly one cycle.
- Odd shift, STEP=2: a=32'h0000_0001, shamt=5, sll at cycle c -> out_valid first in cycle c+4, y=32'h0000_0020; with out_ready held low 3 cycles, y is stable and in_ready=0.
- Arithmetic vs logical: a=32'h8000_0000, shamt=31; sra -> y=32'hFFFF_FFFF (c+17); srl -> y=32'h0000_0001; reserved op 10 with a=1, shamt=4 -> y=32'h10.
- Flush: flush in SHIFT cycle 2 -> IDLE next cycle, out_valid never asserts. Flush in DONE -> result dropped. flush and in_valid together in IDLE -> no accept, and the operation is taken on the following cycle once flush drops.
- Back-to-back: two queued ops (sll 3, srl 1) with out_ready tied high -> second accepted the cycle after the first DONE handshake; y values 8x and x>>1 respectively; busy never glitches low during SHIFT.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types and defaults for the shift sequencer
package shift_pkg;
   typedef enum logic [1:0] {
      SH_SLL = 2'b00,
      SH_SRL = 2'b01,
      SH_RSV = 2'b10,
      SH_SRA = 2'b11
   } shift_op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } seq_state_t;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_STEP  = 2;
endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational shift of acc by 0..STEP bits with direction/fill select
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int STEP  = DEF_STEP,
   parameter int KW    = $clog2(STEP + 1)
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [KW-1:0]    k,
   input  shift_op_t        op,
   output logic [WIDTH-1:0] res
);

   // The reserved encoding falls through to the left shift.
   always_comb begin
      res = acc;
      for (int i = 1; i <= STEP; i++) begin
         if (k == KW'(i)) begin
            case (op)
               SH_SRL:  res = acc >> i;
               SH_SRA:  res = $signed(acc) >>> i;
               default: res = acc << i;
            endcase
         end
      end
   end

endmodule

// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - multi-cycle sll/srl/sra sequencer with valid/ready handshake
module shift_seq
   import shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int STEP  = DEF_STEP,
   parameter int SW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [SW-1:0]    shamt,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             busy
);

   localparam int KW = $clog2(STEP + 1);

   seq_state_t       state;
   logic [WIDTH-1:0] acc;
   logic [SW-1:0]    rem;
   shift_op_t        op_q;
   logic [KW-1:0]    k;
   logic [WIDTH-1:0] acc_next;

   assign k = (rem >= SW'(STEP)) ? KW'(STEP) : KW'(rem);

   shift_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP),
      .KW    (KW)
   ) u_step (
      .acc (acc),
      .k   (k),
      .op  (op_q),
      .res (acc_next)
   );

   assign in_ready  = (state == S_IDLE) && !flush;
   assign busy      = (state != S_IDLE);
   assign out_valid = (state == S_DONE);
   assign y         = out_valid ? acc : '0;

   // flush only returns to IDLE; acc/rem keep their stale contents.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         acc   <= '0;
         rem   <= '0;
         op_q  <= SH_SLL;
      end else if (flush) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  acc   <= a;
                  rem   <= shamt;
                  op_q  <= shift_op_t'(op);
                  state <= (shamt == '0) ? S_DONE : S_SHIFT;
               end
            end
            S_SHIFT: begin
               acc <= acc_next;
               rem <= rem - SW'(k);
               if (rem == SW'(k))
                  state <= S_DONE;
            end
            S_DONE: begin
               if (out_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
